// File: rtl/ppu_timing.sv
// PPU dot/line sequencer: advances one dot per clock and produces ly, PPU mode,
// OAM scan index, the mode-3 start strobe and VBlank/STAT interrupt pulses.
module ppu_timing #(
  parameter int DOTS_PER_LINE = 456,
  parameter int LINES         = 154,
  parameter int XFER_TIMEOUT  = 369
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_lcd_ena,
  input  logic [7:0] i_lyc,
  input  logic [3:0] i_stat_ie,
  input  logic       i_xfer_done,
  output logic [7:0] o_ly,
  output logic [8:0] o_dot,
  output logic [1:0] o_mode,
  output logic       o_lyc_match,
  output logic       o_oam_scan,
  output logic [5:0] o_oam_idx,
  output logic       o_xfer_start,
  output logic       o_irq_vblank,
  output logic       o_irq_stat
);

  localparam logic [8:0] DOT_LAST  = 9'(DOTS_PER_LINE - 1);
  localparam logic [7:0] LY_LAST   = 8'(LINES - 1);
  localparam logic [7:0] LY_VBLANK = 8'd144;
  localparam logic [8:0] DOT_XFER  = 9'd80;
  localparam logic [8:0] DOT_TMO   = 9'(XFER_TIMEOUT);

  typedef enum logic [1:0] {
    MODE_HBLANK = 2'd0,
    MODE_VBLANK = 2'd1,
    MODE_OAM    = 2'd2,
    MODE_XFER   = 2'd3
  } mode_e;

  mode_e      r_mode;
  mode_e      w_mode_nxt;
  logic       r_run;
  logic [8:0] r_dot;
  logic [7:0] r_ly;
  logic [8:0] w_dot_nxt;
  logic [7:0] w_ly_nxt;

  logic       r_lyc_match;
  logic       r_oam_scan;
  logic [5:0] r_oam_idx;
  logic       r_xfer_start;
  logic       r_irq_vblank;
  logic       r_irq_stat;
  logic       r_stat_prev;

  logic       w_stat_line;
  logic       w_lyc_match_nxt;
  logic       w_oam_scan_nxt;
  logic [5:0] w_oam_idx_nxt;
  logic       w_xfer_start_nxt;
  logic       w_irq_vblank_nxt;
  logic       w_irq_stat_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode <= MODE_HBLANK;
      r_run  <= 1'b0;
      r_dot  <= '0;
      r_ly   <= '0;
    end else begin
      r_mode <= w_mode_nxt;
      r_run  <= i_lcd_ena;
      r_dot  <= w_dot_nxt;
      r_ly   <= w_ly_nxt;
    end
  end

  // The first enabled edge parks the counters at dot 0 / line 0 instead of advancing.
  always_comb begin
    w_dot_nxt  = '0;
    w_ly_nxt   = '0;
    w_mode_nxt = MODE_HBLANK;
    if (i_lcd_ena && r_run) begin
      if (r_dot == DOT_LAST) begin
        w_ly_nxt = (r_ly == LY_LAST) ? 8'd0 : r_ly + 8'd1;
      end else begin
        w_dot_nxt = r_dot + 9'd1;
        w_ly_nxt  = r_ly;
      end
    end
    if (!i_lcd_ena)
      w_mode_nxt = MODE_HBLANK;
    else if (w_ly_nxt >= LY_VBLANK)
      w_mode_nxt = MODE_VBLANK;
    else if (w_dot_nxt < DOT_XFER)
      w_mode_nxt = MODE_OAM;
    else if (w_dot_nxt == DOT_XFER)
      w_mode_nxt = MODE_XFER;
    else if (r_mode == MODE_XFER && !i_xfer_done && w_dot_nxt < DOT_TMO)
      w_mode_nxt = MODE_XFER;
    else
      w_mode_nxt = MODE_HBLANK;
  end

  always_comb begin
    w_stat_line = r_run & ((i_stat_ie[3] & r_lyc_match) |
                           (i_stat_ie[2] & (r_mode == MODE_OAM)) |
                           (i_stat_ie[1] & (r_mode == MODE_VBLANK)) |
                           (i_stat_ie[0] & (r_mode == MODE_HBLANK)));
    w_lyc_match_nxt  = (w_ly_nxt == i_lyc);
    w_oam_scan_nxt   = (w_mode_nxt == MODE_OAM);
    w_oam_idx_nxt    = w_oam_scan_nxt ? w_dot_nxt[6:1] : 6'd0;
    w_xfer_start_nxt = (w_ly_nxt < LY_VBLANK) && (w_dot_nxt == DOT_XFER);
    w_irq_vblank_nxt = (w_ly_nxt == LY_VBLANK) && (w_dot_nxt == 9'd0);
    w_irq_stat_nxt   = i_lcd_ena & w_stat_line & ~r_stat_prev;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lyc_match  <= 1'b0;
      r_oam_scan   <= 1'b0;
      r_oam_idx    <= '0;
      r_xfer_start <= 1'b0;
      r_irq_vblank <= 1'b0;
      r_irq_stat   <= 1'b0;
      r_stat_prev  <= 1'b0;
    end else begin
      r_lyc_match  <= w_lyc_match_nxt;
      r_oam_scan   <= w_oam_scan_nxt;
      r_oam_idx    <= w_oam_idx_nxt;
      r_xfer_start <= w_xfer_start_nxt;
      r_irq_vblank <= w_irq_vblank_nxt;
      r_irq_stat   <= w_irq_stat_nxt;
      r_stat_prev  <= i_lcd_ena & w_stat_line;
    end
  end

  assign o_ly         = r_ly;
  assign o_dot        = r_dot;
  assign o_mode       = r_mode;
  assign o_lyc_match  = r_lyc_match;
  assign o_oam_scan   = r_oam_scan;
  assign o_oam_idx    = r_oam_idx;
  assign o_xfer_start = r_xfer_start;
  assign o_irq_vblank = r_irq_vblank;
  assign o_irq_stat   = r_irq_stat;

endmodule

// File: tb/tb_ppu_timing.sv
// Bench for ppu_timing: random stimulus checked against a frame-position model.
module tb_ppu_timing;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic [7:0] lyc = 8'd0;
  logic [3:0] ie = 4'd0;
  logic       xd = 1'b0;

  logic [7:0] o_ly;
  logic [8:0] o_dot;
  logic [1:0] o_mode;
  logic       o_lyc_match;
  logic       o_oam_scan;
  logic [5:0] o_oam_idx;
  logic       o_xfer_start;
  logic       o_irq_vblank;
  logic       o_irq_stat;

  int total = 0;
  int bad = 0;

  ppu_timing dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_lcd_ena    (ena),
    .i_lyc        (lyc),
    .i_stat_ie    (ie),
    .i_xfer_done  (xd),
    .o_ly         (o_ly),
    .o_dot        (o_dot),
    .o_mode       (o_mode),
    .o_lyc_match  (o_lyc_match),
    .o_oam_scan   (o_oam_scan),
    .o_oam_idx    (o_oam_idx),
    .o_xfer_start (o_xfer_start),
    .o_irq_vblank (o_irq_vblank),
    .o_irq_stat   (o_irq_stat)
  );

  always #5 clk = ~clk;

  localparam int FRAME = 456 * 154;

  // Model: position within the frame plus the dot at which HBlank starts on this line.
  bit m_run = 0;
  int m_pos = 0;
  int m_end = 369;
  int m_dot = 0;
  int m_ly = 0;
  int m_mode = 0;
  bit m_lyc_match = 0, m_oam_scan = 0, m_xs = 0, m_vb = 0, m_irq = 0, m_line_prev = 0;
  int m_oam_idx = 0;

  task automatic model_step();
    bit line;
    if (!rst_n || !ena) begin
      m_run = 0; m_pos = 0; m_end = 369; m_dot = 0; m_ly = 0; m_mode = 0;
      m_oam_scan = 0; m_oam_idx = 0; m_xs = 0; m_vb = 0; m_irq = 0; m_line_prev = 0;
      m_lyc_match = rst_n ? (lyc == 8'd0) : 1'b0;
      return;
    end
    line = m_run && ((ie[3] && m_lyc_match) || (ie[2] && m_mode == 2) ||
                     (ie[1] && m_mode == 1) || (ie[0] && m_mode == 0));
    m_irq = line && !m_line_prev;
    m_line_prev = line;
    if (m_run) begin
      if (m_mode == 3 && xd && m_dot + 1 < m_end) m_end = m_dot + 1;
      m_pos = (m_pos + 1) % FRAME;
    end else begin
      m_run = 1;
      m_pos = 0;
    end
    m_dot = m_pos % 456;
    m_ly  = m_pos / 456;
    if (m_dot == 0) m_end = 369;
    if (m_ly >= 144)       m_mode = 1;
    else if (m_dot < 80)   m_mode = 2;
    else if (m_dot < m_end) m_mode = 3;
    else                   m_mode = 0;
    m_oam_scan  = (m_mode == 2);
    m_oam_idx   = (m_mode == 2) ? m_dot / 2 : 0;
    m_xs        = (m_ly < 144) && (m_dot == 80);
    m_vb        = (m_ly == 144) && (m_dot == 0);
    m_lyc_match = (m_ly == int'(lyc));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  function automatic logic [29:0] dut_vec();
    return {o_ly, o_dot, o_mode, o_lyc_match, o_oam_scan, o_oam_idx,
            o_xfer_start, o_irq_vblank, o_irq_stat};
  endfunction

  function automatic logic [29:0] model_vec();
    return {8'(m_ly), 9'(m_dot), 2'(m_mode), m_lyc_match, m_oam_scan, 6'(m_oam_idx),
            m_xs, m_vb, m_irq};
  endfunction

  task automatic test_reset();
    rst_n = 0; ena = 0; lyc = 8'd77; ie = 4'hF; xd = 0;
    repeat (3) tick();
    total++;
    if (dut_vec() !== 30'd0) begin
      bad++; $display("FAIL reset_hold: got %h want 0", dut_vec());
    end
    rst_n = 1;
    for (int i = 0; i < 100; i++) begin
      tick();
      total++;
      if (dut_vec() !== 30'd0) begin
        bad++; $display("FAIL idle_outputs cyc %0d: got %h want 0", i, dut_vec());
      end
    end
  endtask

  task automatic test_line0();
    logic [1:0] exp_mode;
    logic [5:0] exp_idx;
    lyc = 8'd200; ie = 4'd0; ena = 1;
    for (int i = 0; i < 457; i++) begin
      xd = m_run && m_ly == 0 && m_dot == 251;
      tick();
      total++;
      if (dut_vec() !== model_vec()) begin
        bad++; $display("FAIL line0_vec cyc %0d: got %h want %h", i, dut_vec(), model_vec());
      end
      if (i < 456) begin
        exp_mode = (i < 80) ? 2'd2 : (i <= 251) ? 2'd3 : 2'd0;
        exp_idx  = (i < 80) ? 6'(i / 2) : 6'd0;
        total++;
        if ({o_mode, o_oam_idx, o_xfer_start} !== {exp_mode, exp_idx, i == 80}) begin
          bad++; $display("FAIL line0_seq dot %0d: got %h/%0d/%b want %h/%0d/%b", i,
                          o_mode, o_oam_idx, o_xfer_start, exp_mode, exp_idx, i == 80);
        end
      end
    end
    xd = 0;
    total++;
    if ({o_ly, o_dot} !== {8'd1, 9'd0}) begin
      bad++; $display("FAIL line0_wrap: got ly %0d dot %0d want ly 1 dot 0", o_ly, o_dot);
    end
  endtask

  task automatic test_timeout();
    logic [1:0] exp_mode;
    for (int i = 0; i < 3 * 456; i++) begin
      case (m_ly)
        1: xd = (m_mode != 3) ? 1'($urandom_range(0, 1)) : 1'b0;
        2: xd = (m_dot == 368);
        3: xd = (m_dot == 80);
        default: xd = 1'b0;
      endcase
      tick();
      total++;
      if (dut_vec() !== model_vec()) begin
        bad++; $display("FAIL timeout_vec cyc %0d: got %h want %h", i, dut_vec(), model_vec());
      end
      if (m_ly == 3) exp_mode = (m_dot < 80) ? 2'd2 : (m_dot == 80) ? 2'd3 : 2'd0;
      else           exp_mode = (m_dot < 80) ? 2'd2 : (m_dot < 369) ? 2'd3 : 2'd0;
      if (m_ly >= 1 && m_ly <= 3) begin
        total++;
        if (o_mode !== exp_mode) begin
          bad++; $display("FAIL timeout_mode ly %0d dot %0d: got %0d want %0d",
                          m_ly, m_dot, o_mode, exp_mode);
        end
      end
    end
    xd = 0;
    total++;
    if ({o_ly, o_dot} !== {8'd4, 9'd0}) begin
      bad++; $display("FAIL timeout_pos: got ly %0d dot %0d want ly 4 dot 0", o_ly, o_dot);
    end
  endtask

  task automatic test_stat();
    int cnt[3];
    int entry = -1;
    int pulse_dot = -1;
    cnt = '{0, 0, 0};
    lyc = 8'd5; ie = 4'b1001;
    for (int i = 0; i < 3 * 456; i++) begin
      xd = (m_mode == 3) && ($urandom_range(0, 99) == 0);
      tick();
      total++;
      if (dut_vec() !== model_vec()) begin
        bad++; $display("FAIL stat_vec cyc %0d: got %h want %h", i, dut_vec(), model_vec());
      end
      if (m_ly >= 4 && m_ly <= 6 && o_irq_stat) cnt[m_ly - 4]++;
      if (m_ly == 4 && m_mode == 0 && entry < 0) entry = m_dot;
      if (m_ly == 4 && o_irq_stat) pulse_dot = m_dot;
    end
    xd = 0;
    total++;
    if (cnt[0] != 1 || cnt[1] != 0 || cnt[2] != 1) begin
      bad++; $display("FAIL stat_count: got %0d,%0d,%0d want 1,0,1", cnt[0], cnt[1], cnt[2]);
    end
    total++;
    if (pulse_dot != entry + 1) begin
      bad++; $display("FAIL stat_when: got dot %0d want dot %0d", pulse_dot, entry + 1);
    end
  endtask

  task automatic test_disable();
    bit reached = 0;
    ie = 4'b0001;
    for (int i = 0; i < 5 * 456 && !reached; i++) begin
      xd = (m_ly == 10) ? (m_dot == 149) : ((m_mode == 3) && ($urandom_range(0, 49) == 0));
      tick();
      total++;
      if (dut_vec() !== model_vec()) begin
        bad++; $display("FAIL disable_vec cyc %0d: got %h want %h", i, dut_vec(), model_vec());
      end
      reached = (m_ly == 10 && m_dot == 150);
    end
    xd = 0;
    total++;
    if (!reached) begin
      bad++; $display("FAIL disable_reach: got ly %0d dot %0d want ly 10 dot 150", o_ly, o_dot);
    end
    ena = 0;
    tick();
    total++;
    if ({o_ly, o_dot, o_mode, o_oam_scan, o_irq_stat, o_irq_vblank, o_xfer_start} !== 23'd0) begin
      bad++; $display("FAIL disable_idle: got ly %0d dot %0d mode %0d irq %b/%b", o_ly, o_dot,
                      o_mode, o_irq_stat, o_irq_vblank);
    end
    lyc = 8'd0; ie = 4'hF;
    for (int i = 0; i < 20; i++) begin
      tick();
      total++;
      if ({o_lyc_match, o_mode, o_irq_stat, o_irq_vblank, o_oam_scan} !== 6'b1_00_000) begin
        bad++; $display("FAIL idle_track cyc %0d: got %b want 100000", i,
                        {o_lyc_match, o_mode, o_irq_stat, o_irq_vblank, o_oam_scan});
      end
    end
    lyc = 8'd3;
    tick();
    total++;
    if (o_lyc_match !== 1'b0) begin
      bad++; $display("FAIL idle_lyc: got %b want 0", o_lyc_match);
    end
    ena = 1;
    tick();
    total++;
    if ({o_ly, o_dot, o_mode, o_oam_scan} !== {8'd0, 9'd0, 2'd2, 1'b1}) begin
      bad++; $display("FAIL reenable: got ly %0d dot %0d mode %0d want 0 0 2", o_ly, o_dot, o_mode);
    end
  endtask

  task automatic test_frame();
    int vb_cnt = 0;
    int vb_at = -1;
    for (int i = 1; i <= FRAME; i++) begin
      if (m_dot == 0) ie = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 999) == 0) lyc = 8'($urandom_range(0, 153));
      xd = (m_mode == 3) && ($urandom_range(0, 199) == 0);
      tick();
      total++;
      if (dut_vec() !== model_vec()) begin
        bad++; $display("FAIL frame_vec pos %0d: got %h want %h", i, dut_vec(), model_vec());
      end
      if (o_irq_vblank) begin
        vb_cnt++; vb_at = i;
      end
      if (m_ly >= 144) begin
        total++;
        if (o_mode !== 2'd1) begin
          bad++; $display("FAIL frame_vblank_mode ly %0d: got %0d want 1", m_ly, o_mode);
        end
      end
      if (i == FRAME - 1) begin
        total++;
        if ({o_ly, o_dot} !== {8'd153, 9'd455}) begin
          bad++; $display("FAIL frame_last: got ly %0d dot %0d want 153 455", o_ly, o_dot);
        end
      end
    end
    xd = 0;
    total++;
    if ({o_ly, o_dot, o_mode} !== {8'd0, 9'd0, 2'd2}) begin
      bad++; $display("FAIL frame_wrap: got ly %0d dot %0d mode %0d want 0 0 2", o_ly, o_dot, o_mode);
    end
    total++;
    if (vb_cnt != 1 || vb_at != 144 * 456) begin
      bad++; $display("FAIL frame_vblank: got %0d pulses at %0d want 1 at %0d", vb_cnt, vb_at, 144 * 456);
    end
  endtask

  task automatic test_midreset();
    ie = 4'b0110;
    for (int i = 0; i < 656; i++) begin
      xd = (m_mode == 3) && ($urandom_range(0, 99) == 0);
      tick();
      total++;
      if (dut_vec() !== model_vec()) begin
        bad++; $display("FAIL midrst_vec cyc %0d: got %h want %h", i, dut_vec(), model_vec());
      end
    end
    xd = 0;
    rst_n = 0;
    #1;
    total++;
    if (dut_vec() !== 30'd0) begin
      bad++; $display("FAIL midrst_async: got %h want 0", dut_vec());
    end
    tick();
    rst_n = 1;
    for (int i = 0; i < 12; i++) begin
      tick();
      total++;
      if (dut_vec() !== model_vec()) begin
        bad++; $display("FAIL midrst_restart cyc %0d: got %h want %h", i, dut_vec(), model_vec());
      end
      if (i == 0) begin
        total++;
        if ({o_ly, o_dot, o_mode} !== {8'd0, 9'd0, 2'd2}) begin
          bad++; $display("FAIL midrst_first: got ly %0d dot %0d mode %0d want 0 0 2",
                          o_ly, o_dot, o_mode);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_line0();
    test_timeout();
    test_stat();
    test_disable();
    test_frame();
    test_midreset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
